// File: rtl/cntr8_pkg.sv
// Shared definitions for the cntr8 command sequencer: counter state codes,
// sequencer FSM encoding and the step-state legality rule.
package cntr8_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_INC  = 3'b010,
        ST_INC2 = 3'b011,
        ST_DEC  = 3'b100,
        ST_DEC2 = 3'b101
    } cnt_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SETTLE,
        S_CHECK
    } seq_state_e;

    // A stepping counter must report a state matching the commanded direction.
    function automatic logic step_state_ok(input logic dir, input logic [2:0] o_state);
        if (dir) return (o_state == ST_INC) || (o_state == ST_INC2);
        else     return (o_state == ST_DEC) || (o_state == ST_DEC2);
    endfunction

endpackage

// File: rtl/cntr8_seq_mon.sv
// Counter result checker: flags a wrong o_state while stepping and a wrong
// parked value/state at the final check; the flag is sticky until cleared.
module cntr8_seq_mon
    import cntr8_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             run_en_i,
    input  logic             check_en_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] target_i,
    input  logic [CNT_W-1:0] cnt_d_out_i,
    input  logic [2:0]       cnt_o_state_i,
    output logic             err_o
);

    logic err_q;
    logic run_bad;
    logic check_bad;

    assign run_bad   = run_en_i && !step_state_ok(dir_i, cnt_o_state_i);
    assign check_bad = check_en_i &&
                       ((cnt_d_out_i != target_i) || (cnt_o_state_i != ST_LOAD));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  err_q <= 1'b0;
        else if (clear_i)              err_q <= 1'b0;
        else if (run_bad || check_bad) err_q <= 1'b1;
    end

    assign err_o = err_q;

endmodule

// File: rtl/cntr8_seq.sv
// Sequencer driving a cntr8 counter: load start value, step to target,
// park on target, then verify the counter and report done/err.
module cntr8_seq
    import cntr8_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] start_val,
    input  logic [CNT_W-1:0] target,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] step_cnt,
    output logic             cnt_load,
    output logic             cnt_inc,
    output logic [CNT_W-1:0] cnt_d_in,
    input  logic [CNT_W-1:0] cnt_d_out,
    input  logic [2:0]       cnt_o_state
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] cnt_d_in_q, cnt_d_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_load_q, cnt_load_d;
    logic             cnt_inc_q, cnt_inc_d;
    logic             mon_clear;

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        dir_d      = dir_q;
        rem_d      = rem_q;
        step_cnt_d = step_cnt_q;
        cnt_d_in_d = cnt_d_in_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_load_d = cnt_load_q;
        cnt_inc_d  = cnt_inc_q;
        mon_clear  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    target_d   = target;
                    dir_d      = dir;
                    rem_d      = dir ? (target - start_val) : (start_val - target);
                    step_cnt_d = '0;
                    cnt_d_in_d = start_val;
                    cnt_load_d = 1'b1;
                    cnt_inc_d  = 1'b0;
                    busy_d     = 1'b1;
                    mon_clear  = 1'b1;
                end
            end
            S_LOAD: begin
                if (rem_q != '0) begin
                    state_d    = S_RUN;
                    cnt_load_d = 1'b0;
                    cnt_inc_d  = dir_q;
                end else begin
                    state_d    = S_SETTLE;
                    cnt_d_in_d = target_q;
                end
            end
            S_RUN: begin
                rem_d      = rem_q - 1'b1;
                step_cnt_d = step_cnt_q + 1'b1;
                // Last step edge: re-park on target so the counter stops next edge.
                if (rem_q == CNT_W'(1)) begin
                    state_d    = S_SETTLE;
                    cnt_load_d = 1'b1;
                    cnt_inc_d  = 1'b0;
                    cnt_d_in_d = target_q;
                end
            end
            S_SETTLE: state_d = S_CHECK;
            S_CHECK: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            dir_q      <= 1'b0;
            rem_q      <= '0;
            step_cnt_q <= '0;
            cnt_d_in_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_load_q <= 1'b1;
            cnt_inc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            dir_q      <= dir_d;
            rem_q      <= rem_d;
            step_cnt_q <= step_cnt_d;
            cnt_d_in_q <= cnt_d_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_load_q <= cnt_load_d;
            cnt_inc_q  <= cnt_inc_d;
        end
    end

    cntr8_seq_mon u_mon (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear_i       (mon_clear),
        .run_en_i      (state_q == S_RUN),
        .check_en_i    (state_q == S_CHECK),
        .dir_i         (dir_q),
        .target_i      (target_q),
        .cnt_d_out_i   (cnt_d_out),
        .cnt_o_state_i (cnt_o_state),
        .err_o         (err)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign step_cnt = step_cnt_q;
    assign cnt_load = cnt_load_q;
    assign cnt_inc  = cnt_inc_q;
    assign cnt_d_in = cnt_d_in_q;

endmodule
